// File: rtl/text_fill_scroll_engine.sv
// text_fill_scroll_engine: hardware clear / scroll-up-one-row engine for the character buffer.
// Latency: idle pass-through is combinational; clear takes N cycles, scroll N+1, done one cycle after the last write.
// Backpressure: none; CPU writes arriving while busy are discarded (cpu_drop), commands while busy queue in one pending slot.
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   clear_screen, scroll_screen    one-cycle command pulses
//   mode_80col                     0 = 40 columns, 1 = 80 columns (sampled when an operation starts)
//   cpu_addr/cpu_data/cpu_we       CPU write request, forwarded when idle
//   rd_addr / rd_data              buffer read port (rd_data is registered, 1-cycle latency)
//   mem_addr/mem_data/mem_we       buffer write port
//   busy, done, cpu_drop           status: engine owns port, op-complete pulse, dropped CPU write
//
// Note: 80-column mode needs enough address bits for ROWS*80 cells (ROWS=30 -> 2400 -> ADDR_W=12).
module text_fill_scroll_engine #(
  parameter int          ROWS      = 30,
  parameter logic [7:0]  FILL_CHAR = 8'h20,
  parameter int          ADDR_W    = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_screen,
  input  logic              scroll_screen,
  input  logic              mode_80col,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_data,
  input  logic              cpu_we,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              mem_we,
  output logic              busy,
  output logic              done,
  output logic              cpu_drop
);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_COPY, S_FILL} state_t;

  localparam logic [ADDR_W-1:0] COLS40 = ADDR_W'(40);
  localparam logic [ADDR_W-1:0] COLS80 = ADDR_W'(80);
  localparam logic [ADDR_W-1:0] N40    = ADDR_W'(ROWS * 40);
  localparam logic [ADDR_W-1:0] N80    = ADDR_W'(ROWS * 80);
  localparam logic [ADDR_W-1:0] ONE    = ADDR_W'(1);

  state_t            state_q;
  logic [ADDR_W-1:0] cnt_q;       // CLEAR/FILL: cell address; COPY: cycle index k
  logic [ADDR_W-1:0] wa_q;        // registered write address presented on mem_addr
  logic [ADDR_W-1:0] rd_addr_q;
  logic              we_q;
  logic              done_q;
  logic              c80_q;       // geometry latched at operation start
  logic              pend_clr_q;
  logic              pend_scr_q;

  logic [ADDR_W-1:0] cols_w, n_w, m_w, n_last, cnt_inc, new_cols;
  logic              is_busy, last_wr, cmd_clr, cmd_scr;

  assign cols_w   = c80_q ? COLS80 : COLS40;
  assign n_w      = c80_q ? N80 : N40;
  assign m_w      = n_w - cols_w;
  assign n_last   = n_w - ONE;
  assign cnt_inc  = cnt_q + ONE;
  assign new_cols = mode_80col ? COLS80 : COLS40;

  assign is_busy  = (state_q != S_IDLE);
  // CLEAR and FILL both finish on the write to the final cell N-1.
  assign last_wr  = ((state_q == S_CLEAR) || (state_q == S_FILL)) && (cnt_q == n_last);

  // Start conditions: from idle on a pulse, or back-to-back on the completing edge
  // if a command is pending (a pulse landing on the last write cycle also counts).
  // Clear always beats scroll; the losing scroll is dropped.
  assign cmd_clr = is_busy ? (last_wr && (pend_clr_q || clear_screen)) : clear_screen;
  assign cmd_scr = !cmd_clr &&
                   (is_busy ? (last_wr && (pend_scr_q || scroll_screen)) : scroll_screen);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      wa_q       <= '0;
      rd_addr_q  <= '0;
      we_q       <= 1'b0;
      done_q     <= 1'b0;
      c80_q      <= 1'b0;
      pend_clr_q <= 1'b0;
      pend_scr_q <= 1'b0;
    end else begin
      done_q <= 1'b0;

      if (is_busy) begin
        if (clear_screen)  pend_clr_q <= 1'b1;
        if (scroll_screen) pend_scr_q <= 1'b1;
      end

      case (state_q)
        S_CLEAR, S_FILL: begin
          cnt_q <= cnt_inc;
          wa_q  <= cnt_inc;
          if (last_wr) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        S_COPY: begin
          // Cycle k reads cell k+COLS; the data returns in cycle k+1 and is written to k.
          cnt_q <= cnt_inc;
          wa_q  <= cnt_q;
          we_q  <= 1'b1;
          if (cnt_inc < m_w) rd_addr_q <= cnt_inc + cols_w;
          if (cnt_q == m_w) begin
            state_q <= S_FILL;
            cnt_q   <= m_w;
            wa_q    <= m_w;
          end
        end
        default: ;
      endcase

      if (cmd_clr) begin
        state_q    <= S_CLEAR;
        cnt_q      <= '0;
        wa_q       <= '0;
        we_q       <= 1'b1;
        c80_q      <= mode_80col;
        pend_clr_q <= 1'b0;
        pend_scr_q <= 1'b0;
      end else if (cmd_scr) begin
        state_q    <= S_COPY;
        cnt_q      <= '0;
        we_q       <= 1'b0;
        rd_addr_q  <= new_cols;
        c80_q      <= mode_80col;
        pend_clr_q <= 1'b0;
        pend_scr_q <= 1'b0;
      end
    end
  end

  // Write port mux: CPU pass-through when idle, engine registers when busy.
  // COPY data comes straight from the buffer's registered read port.
  always_comb begin
    mem_addr = cpu_addr;
    mem_data = cpu_data;
    mem_we   = cpu_we;
    if (is_busy) begin
      mem_addr = wa_q;
      mem_data = (state_q == S_COPY) ? rd_data : FILL_CHAR;
      mem_we   = we_q;
    end
    if (rst) mem_we = 1'b0;
  end

  assign rd_addr  = rd_addr_q;
  assign busy     = is_busy;
  assign done     = done_q;
  assign cpu_drop = is_busy & cpu_we;

endmodule

// File: tb/tb_text_fill_scroll_engine.sv
`timescale 1ns/1ps
module tb_text_fill_scroll_engine;
  localparam int ROWS = 30;
  localparam int AW   = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clear_screen = 1'b0, scroll_screen = 1'b0, mode_80col = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [7:0]    cpu_data = '0;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] rd_addr, mem_addr;
  logic [7:0]    rd_data, mem_data;
  logic          mem_we, busy, done, cpu_drop;

  text_fill_scroll_engine #(.ROWS(ROWS), .FILL_CHAR(8'h20), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .clear_screen(clear_screen), .scroll_screen(scroll_screen),
    .mode_80col(mode_80col), .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_we(cpu_we),
    .rd_addr(rd_addr), .rd_data(rd_data), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_we(mem_we), .busy(busy), .done(done), .cpu_drop(cpu_drop)
  );

  always #5 clk = ~clk;

  // Character buffer: synchronous write, registered read.
  logic [7:0] mem   [0:4095];
  logic [7:0] model [0:4095];
  logic       fill_req = 1'b0;
  logic [7:0] fill_key = 8'h00;

  always @(posedge clk) begin
    if (fill_req) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 8'(i) ^ fill_key;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_data;
    end
    rd_data <= mem[rd_addr];
  end

  typedef struct packed { logic [AW-1:0] addr; logic [7:0] data; } wr_t;
  wr_t exp_q[$];

  int checks = 0, errors = 0;
  int busy_cnt = 0, done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every engine write must match the head of the expected queue.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (busy) busy_cnt++;
        if (done) done_cnt++;
        if (busy && mem_we) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected_write: got addr %0d data %h, expected no write", mem_addr, mem_data);
          end else begin
            e = exp_q.pop_front();
            if (mem_addr !== e.addr || mem_data !== e.data) begin
              errors++;
              $display("FAIL sb_write: got addr %0d data %h, expected addr %0d data %h",
                       mem_addr, mem_data, e.addr, e.data);
            end
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic fill_buf(input logic [7:0] key);
    fill_key = key;
    fill_req = 1'b1;
    step();
    fill_req = 1'b0;
    for (int i = 0; i < 4096; i++) model[i] = 8'(i) ^ key;
  endtask

  task automatic push_wr(input int a, input logic [7:0] d);
    wr_t w;
    w.addr = AW'(a);
    w.data = d;
    exp_q.push_back(w);
  endtask

  task automatic push_clear(input int cols);
    for (int i = 0; i < ROWS * cols; i++) begin
      push_wr(i, 8'h20);
      model[i] = 8'h20;
    end
  endtask

  task automatic push_scroll(input int cols);
    int n, m;
    n = ROWS * cols;
    m = n - cols;
    for (int i = 0; i < m; i++) begin
      push_wr(i, model[i + cols]);
      model[i] = model[i + cols];
    end
    for (int i = m; i < n; i++) begin
      push_wr(i, 8'h20);
      model[i] = 8'h20;
    end
  endtask

  task automatic cmp_mem(input string name);
    int bad;
    bad = 0;
    for (int i = 0; i < 4096; i++) if (mem[i] !== model[i]) bad++;
    chk(name, bad, 0);
  endtask

  task automatic wait_done(input string tag, input int limit, output logic busy_at);
    logic seen, prev_wr;
    seen = 1'b0;
    prev_wr = 1'b0;
    busy_at = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        busy_at = busy;
        chk({tag, "_done_after_last_write"}, prev_wr, 1);
      end
      prev_wr = mem_we && busy;
    end
    if (!seen) chk({tag, "_done_timeout"}, 0, 1);
  endtask

  typedef struct {
    logic [AW-1:0] addr; logic [7:0] data; logic we;
    logic [AW-1:0] e_addr; logic [7:0] e_data; logic e_we; logic e_drop;
  } vec_t;
  vec_t vecs [6];

  initial begin
    logic b;
    logic hit;

    vecs[0] = '{12'd5,    8'h41, 1'b1, 12'd5,    8'h41, 1'b1, 1'b0};
    vecs[1] = '{12'd0,    8'h00, 1'b0, 12'd0,    8'h00, 1'b0, 1'b0};
    vecs[2] = '{12'd2399, 8'hFF, 1'b1, 12'd2399, 8'hFF, 1'b1, 1'b0};
    vecs[3] = '{12'd1199, 8'h20, 1'b1, 12'd1199, 8'h20, 1'b1, 1'b0};
    vecs[4] = '{12'h800,  8'h5A, 1'b0, 12'h800,  8'h5A, 1'b0, 1'b0};
    vecs[5] = '{12'h7FF,  8'hA5, 1'b1, 12'h7FF,  8'hA5, 1'b1, 1'b0};

    // Reset state, with a CPU write request held high.
    cpu_addr = 12'd9; cpu_data = 8'hAB; cpu_we = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cpu_drop", cpu_drop, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_mem_we_forced_low", mem_we, 0);
    cpu_we = 1'b0;
    rst = 1'b0;
    step();

    // Idle pass-through vectors.
    for (int i = 0; i < 6; i++) begin
      cpu_addr = vecs[i].addr; cpu_data = vecs[i].data; cpu_we = vecs[i].we;
      #1;
      chk($sformatf("idle_vec%0d", i), {mem_addr, mem_data, mem_we, cpu_drop},
          {vecs[i].e_addr, vecs[i].e_data, vecs[i].e_we, vecs[i].e_drop});
      step();
    end
    cpu_we = 1'b0;

    // 40-column clear with a dropped CPU write in the middle.
    mode_80col = 1'b0;
    fill_buf(8'h5A);
    busy_cnt = 0; done_cnt = 0;
    push_clear(40);
    clear_screen = 1'b1;
    step();
    clear_screen = 1'b0;
    chk("clr40_busy_rise", busy, 1);
    repeat (300) step();
    cpu_addr = 12'd5; cpu_data = 8'h41; cpu_we = 1'b1;
    #1;
    chk("clr40_cpu_drop", cpu_drop, 1);
    chk("clr40_drop_mem_data", mem_data, 8'h20);
    step();
    cpu_we = 1'b0;
    #1;
    chk("clr40_cpu_drop_pulse", cpu_drop, 0);
    wait_done("clr40", 1300, b);
    chk("clr40_busy_at_done", b, 0);
    step();
    chk("clr40_busy_cycles", busy_cnt, 1200);
    chk("clr40_done_count", done_cnt, 1);
    chk("clr40_queue_empty", exp_q.size(), 0);
    chk("clr40_cell5", mem[5], 8'h20);
    chk("clr40_cell1200_untouched", mem[1200], 8'(1200) ^ 8'h5A);
    cmp_mem("clr40_mem");

    // Same CPU write in idle reaches the buffer port in the same cycle.
    cpu_addr = 12'd5; cpu_data = 8'h41; cpu_we = 1'b1;
    #1;
    chk("idle_write_now", {mem_we, mem_addr, mem_data}, {1'b1, 12'd5, 8'h41});
    step();
    cpu_we = 1'b0;
    model[5] = 8'h41;
    chk("idle_write_cell5", mem[5], 8'h41);

    // 80-column scroll; mode flips mid-operation and must not disturb it.
    mode_80col = 1'b1;
    fill_buf(8'h00);
    busy_cnt = 0; done_cnt = 0;
    push_scroll(80);
    scroll_screen = 1'b1;
    step();
    scroll_screen = 1'b0;
    chk("scr80_busy_rise", busy, 1);
    repeat (1000) step();
    mode_80col = 1'b0;
    wait_done("scr80", 2500, b);
    chk("scr80_busy_at_done", b, 0);
    step();
    chk("scr80_busy_cycles", busy_cnt, 2401);
    chk("scr80_done_count", done_cnt, 1);
    chk("scr80_queue_empty", exp_q.size(), 0);
    chk("scr80_cell0", mem[0], 8'h50);
    chk("scr80_cell2319", mem[2319], 8'h5F);
    chk("scr80_cell2320", mem[2320], 8'h20);
    cmp_mem("scr80_mem");

    // Next operation picks up the new 40-column mode.
    busy_cnt = 0;
    push_clear(40);
    clear_screen = 1'b1;
    step();
    clear_screen = 1'b0;
    wait_done("clr_after_mode", 1300, b);
    step();
    chk("clr_after_mode_busy_cycles", busy_cnt, 1200);
    cmp_mem("clr_after_mode_mem");

    // Simultaneous clear+scroll, then two scroll pulses during the clear.
    fill_buf(8'hC3);
    busy_cnt = 0; done_cnt = 0;
    push_clear(40);
    clear_screen = 1'b1; scroll_screen = 1'b1;
    step();
    clear_screen = 1'b0; scroll_screen = 1'b0;
    repeat (100) step();
    push_scroll(40);
    scroll_screen = 1'b1;
    step();
    scroll_screen = 1'b0;
    repeat (100) step();
    scroll_screen = 1'b1;
    step();
    scroll_screen = 1'b0;
    wait_done("pend_clr", 1300, b);
    chk("pend_no_idle_gap", b, 1);
    wait_done("pend_scr", 1300, b);
    chk("pend_scr_busy_at_done", b, 0);
    repeat (20) step();
    chk("pend_busy_cycles", busy_cnt, 2401);
    chk("pend_done_count", done_cnt, 2);
    chk("pend_queue_empty", exp_q.size(), 0);
    cmp_mem("pend_mem");

    // Reset in the middle of a clear, while write 600 is on the port.
    fill_buf(8'h33);
    for (int i = 0; i <= 600; i++) push_wr(i, 8'h20);
    for (int i = 0; i < 600; i++) model[i] = 8'h20;
    clear_screen = 1'b1;
    step();
    clear_screen = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 1300 && !hit; i++) begin
      @(negedge clk);
      if (busy && mem_we && mem_addr == 12'd600) hit = 1'b1;
    end
    if (!hit) chk("rst_mid_timeout", 0, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_mem_we", mem_we, 0);
    chk("rst_mid_done", done, 0);
    step();
    step();
    rst = 1'b0;
    step();
    chk("rst_mid_idle", busy, 0);
    chk("rst_mid_queue_empty", exp_q.size(), 0);
    chk("rst_mid_cell600", mem[600], 8'(600) ^ 8'h33);
    cmp_mem("rst_mid_mem");
    cpu_addr = 12'd700; cpu_data = 8'h77; cpu_we = 1'b1;
    #1;
    chk("rst_mid_passthru", {mem_we, mem_addr, mem_data}, {1'b1, 12'd700, 8'h77});
    step();
    cpu_we = 1'b0;
    chk("rst_mid_cell700", mem[700], 8'h77);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/text_fill_scroll_engine.md
# text_fill_scroll_engine

Hardware clear/scroll accelerator for the character display GPU. It sits between the register block's character-buffer write port and the character buffer, on the CPU clock. On a `clear_screen` or `scroll_screen` pulse it takes over the buffer write port and the buffer's CPU-side read port, so the CPU no longer has to rewrite 1200/2400 cells in software. When idle, CPU writes pass straight through.

## Interface
- `ROWS`, default 30: text rows.
- `FILL_CHAR`, default 8'h20: code written by clear and by scroll's bottom-row fill.
- `ADDR_W`, default 11: buffer address width.

Ports:
- `clk` in 1: CPU clock domain (clk_cpu).
- `rst` in 1: asynchronous, active-high reset.
- `clear_screen` in 1: one-cycle command pulse.
- `scroll_screen` in 1: one-cycle command pulse.
- `mode_80col` in 1: 0 = 40 columns, 1 = 80 columns.
- `cpu_addr` in ADDR_W, `cpu_data` in 8, `cpu_we` in 1: CPU write request from the register block.
- `rd_addr` out ADDR_W: buffer read address.
- `rd_data` in 8: buffer read data, registered, valid 1 cycle after `rd_addr`.
- `mem_addr` out ADDR_W, `mem_data` out 8, `mem_we` out 1: character buffer write port.
- `busy` out 1: engine owns the write port.
- `done` out 1: one-cycle pulse when an operation completes.
- `cpu_drop` out 1: one-cycle pulse when a CPU write is discarded.

## Operation
- Geometry:
  - COLS = 80 if `mode_80col` else 40, latched at operation start.
  - N = ROWS*COLS (1200 or 2400).
  - Linear address = row*COLS + col.
  - All counters are ADDR_W bits wide and never exceed N.
- States: IDLE, CLEAR, COPY, FILL.
- IDLE:
  - `mem_addr`/`mem_data`/`mem_we` equal `cpu_addr`/`cpu_data`/`cpu_we` (combinational, zero latency).
  - `busy` = 0.
- Starting an operation from IDLE:
  - `clear_screen` → CLEAR, count = 0.
  - `scroll_screen` → COPY, k = 0.
  - Both in the same cycle: clear wins and the scroll is discarded.
- CLEAR:
  - Each cycle: `mem_we` = 1, `mem_addr` = count, `mem_data` = FILL_CHAR.
  - Covers addresses 0..N-1, so CLEAR lasts N cycles.
- COPY, with M = N-COLS:
  - Read side: in cycle k (k < M), `rd_addr` = k+COLS.
  - Write side: in cycle k (k ≥ 1), `mem_we` = 1, `mem_addr` = k-1, `mem_data` = `rd_data`.
  - COPY lasts M+1 cycles, then → FILL.
- FILL:
  - Writes FILL_CHAR to addresses M..N-1, one per cycle, for COLS cycles.
- Completion:
  - The last write cycle of CLEAR or FILL is followed by `done` = 1 for one cycle.
  - The state returns to IDLE in that same cycle.
- While `busy`:
  - `cpu_we` is not forwarded, and `cpu_drop` pulses for each such cycle.
  - `mode_80col` changes have no effect on the running operation.
- Pending command (one entry):
  - A command pulse arriving while busy is latched.
  - A pending clear overrides a pending scroll; repeated scroll pulses collapse to one.
  - On the `done` cycle, if a command is pending, the engine goes directly to CLEAR or COPY (no IDLE cycle), re-latches COLS, and clears the pending flag.
- Reset (async, any state):
  - State → IDLE; pending cleared.
  - `busy` = 0, `done` = 0, `cpu_drop` = 0, `rd_addr` = 0.
  - `mem_we` is forced to 0 while `rst` is high.
  - A partially completed clear/scroll leaves the buffer partially updated; no resume.

## Timing
- `busy` rises the cycle after the accepting command pulse and stays high through the last write cycle.
- Clear: the first write is the cycle after the pulse; `busy` lasts N cycles (1200/2400).
- Scroll: `busy` lasts N+1 cycles (1201/2401).
- `done` is asserted the cycle after the last write, coincident with `busy` falling, unless a pending command keeps `busy` high.
- Address sequences increment by exactly 1 per cycle with no gaps.
- `rd_addr` and all `mem_*` outputs are registered while busy.

## Test plan
- 40-col clear: pulse `clear_screen` → 1200 consecutive writes of 8'h20 to addresses 0..1199, then `done` one cycle later; no write to 1200.
- 80-col scroll on a buffer with cell[i] = i[7:0] → cell[i] = (i+80)[7:0] for i < 2320; cells 2320..2399 = 8'h20; `busy` high for 2401 cycles.
- CPU write during busy: `cpu_we` with addr 5, data 8'h41 mid-clear → `cpu_drop` pulse, cell 5 = 8'h20. The same write in IDLE reaches `mem_*` in the same cycle.
- Simultaneous `clear_screen` + `scroll_screen` → clear only (N writes of FILL_CHAR, no read traffic). Then a scroll pulse during the clear → COPY starts on the `done` cycle with no IDLE gap.
- `mode_80col` toggled mid-scroll → sequence completes with the latched COLS; the next operation uses the new mode.
- `rst` asserted at write 600 of a clear → `busy`, `mem_we`, and `done` are 0 immediately. After release, the engine is IDLE with pass-through working, and cells 600..1199 still hold their prior contents.
